// File: rtl/bomb_pkg.sv
// Shared types and helpers for the multi-bomb pool: slot phase encoding,
// the Release command code and the counter-to-phase decode.
package bomb_pkg;

  typedef enum logic [1:0] {
    BOMB    = 2'd0,
    FLAME   = 2'd1,
    EMPTY   = 2'd2,
    RESTORE = 2'd3
  } phase_t;

  localparam logic [2:0] CMD_RELEASE = 3'd4;

  // Counter counts down TOTAL..1; the upper band is the fuse, then flame, then restore.
  function automatic phase_t decode_phase(input int unsigned cnt,
                                          input int unsigned fr,
                                          input int unsigned restore_ticks);
    phase_t p;
    if (cnt == 0)                  p = EMPTY;
    else if (cnt > fr)             p = BOMB;
    else if (cnt > restore_ticks)  p = FLAME;
    else                           p = RESTORE;
    decode_phase = p;
  endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: countdown counter, latched tile position and phase decode.
// load starts a fresh fuse; chain jumps a live bomb straight into its flame.
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int CNT_W         = 10,
  parameter int TOTAL         = 190,
  parameter int FR            = 70,
  parameter int RESTORE_TICKS = 10
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       load,
  input  logic       chain,
  input  logic [3:0] x_in,
  input  logic [3:0] y_in,
  output phase_t     phase,
  output logic [3:0] x,
  output logic [3:0] y
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
      x   <= '0;
      y   <= '0;
    end else if (load) begin
      cnt <= CNT_W'(TOTAL);
      x   <= x_in;
      y   <= y_in;
    end else if (chain) begin
      cnt <= CNT_W'(FR);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign phase = decode_phase(32'(cnt), FR, RESTORE_TICKS);

endmodule

// File: rtl/bomb_pool.sv
// Multi-bomb pool: release edge detect, limit/duplicate checks, lowest-free
// slot allocation and per-slot countdowns. Chain detonation under CHAIN_REACTION_EN.
module bomb_pool
  import bomb_pkg::*;
#(
  parameter int MAX_BOMBS     = 4,
  parameter int CNT_W         = 10,
  parameter int FUSE_TICKS    = 120,
  parameter int FLAME_TICKS   = 60,
  parameter int RESTORE_TICKS = 10,
  parameter int FLAME_RANGE   = 2,
  localparam int CW           = $clog2(MAX_BOMBS + 1)
) (
  input  logic                   frame_clk,
  input  logic                   Reset_n,
  input  logic [2:0]             command,
  input  logic [3:0]             mapX,
  input  logic [3:0]             mapY,
  input  logic [CW-1:0]          bomb_limit,
  output logic [3*MAX_BOMBS-1:0] slot_state,
  output logic [4*MAX_BOMBS-1:0] slot_x,
  output logic [4*MAX_BOMBS-1:0] slot_y,
  output logic [CW-1:0]          active_count,
  output logic                   placed,
  output logic                   place_reject
);

  localparam int TOTAL = FUSE_TICKS + FLAME_TICKS + RESTORE_TICKS;
  localparam int FR    = FLAME_TICKS + RESTORE_TICKS;

  if (TOTAL >= (1 << CNT_W)) begin : g_bad_total
    $error("bomb_pool: FUSE+FLAME+RESTORE does not fit CNT_W");
  end
  if (MAX_BOMBS < 1 || MAX_BOMBS > 8) begin : g_bad_slots
    $error("bomb_pool: MAX_BOMBS must be 1..8");
  end
  if (FLAME_RANGE < 0 || FLAME_RANGE > 15) begin : g_bad_range
    $error("bomb_pool: FLAME_RANGE must be 0..15");
  end

  phase_t               phase [MAX_BOMBS];
  logic [3:0]           sx    [MAX_BOMBS];
  logic [3:0]           sy    [MAX_BOMBS];
  logic [MAX_BOMBS-1:0] load;
  logic [MAX_BOMBS-1:0] chain;
  logic                 prev_release;
  logic                 release_req;
  logic                 accept;
  logic                 dup;
  logic                 any_free;
  logic                 taken;
  logic [CW-1:0]        live;

  // Handshake: a Release is a single-cycle request on the command's rising edge;
  // exactly one of placed/place_reject answers it on the same edge that loads the slot.
  always_comb begin
    live     = '0;
    dup      = 1'b0;
    any_free = 1'b0;
    for (int i = 0; i < MAX_BOMBS; i++) begin
      if (phase[i] != EMPTY) begin
        live = live + CW'(1);
        if (sx[i] == mapX && sy[i] == mapY) dup = 1'b1;
      end else begin
        any_free = 1'b1;
      end
    end
    release_req = (command == CMD_RELEASE) && !prev_release;
    accept      = release_req && (live < bomb_limit) && any_free && !dup;
    load        = '0;
    taken       = 1'b0;
    for (int i = 0; i < MAX_BOMBS; i++) begin
      if (accept && phase[i] == EMPTY && !taken) begin
        load[i] = 1'b1;
        taken   = 1'b1;
      end
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      prev_release <= 1'b0;
      placed       <= 1'b0;
      place_reject <= 1'b0;
    end else begin
      prev_release <= (command == CMD_RELEASE);
      placed       <= accept;
      place_reject <= release_req && !accept;
    end
  end

`ifdef CHAIN_REACTION_EN
  function automatic logic in_range(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] d;
    d        = (a > b) ? (a - b) : (b - a);
    in_range = ({28'd0, d} <= 32'(FLAME_RANGE));
  endfunction

  // Flames only reach along the bomb's row or column; walls are masked downstream.
  always_comb begin
    chain = '0;
    for (int j = 0; j < MAX_BOMBS; j++) begin
      for (int i = 0; i < MAX_BOMBS; i++) begin
        if (i != j && phase[j] == BOMB && phase[i] == FLAME &&
            ((sy[i] == sy[j] && in_range(sx[i], sx[j])) ||
             (sx[i] == sx[j] && in_range(sy[i], sy[j])))) begin
          chain[j] = 1'b1;
        end
      end
    end
  end
`else
  assign chain = '0;
`endif

  for (genvar g = 0; g < MAX_BOMBS; g++) begin : g_slot
    bomb_slot #(
      .CNT_W        (CNT_W),
      .TOTAL        (TOTAL),
      .FR           (FR),
      .RESTORE_TICKS(RESTORE_TICKS)
    ) u_slot (
      .frame_clk(frame_clk),
      .Reset_n  (Reset_n),
      .load     (load[g]),
      .chain    (chain[g]),
      .x_in     (mapX),
      .y_in     (mapY),
      .phase    (phase[g]),
      .x        (sx[g]),
      .y        (sy[g])
    );
    assign slot_state[3*g +: 3] = {1'b0, phase[g]};
    assign slot_x[4*g +: 4]     = sx[g];
    assign slot_y[4*g +: 4]     = sy[g];
  end

  assign active_count = live;

endmodule

// File: tb/tb_bomb_pool.sv
// Bench for bomb_pool: directed scenarios plus random releases, checked every
// cycle against a timeline model of each bomb (placement time, flame start).
module tb_bomb_pool;

  localparam int NB = 4;
  localparam int FU = 4;
  localparam int FL = 3;
  localparam int RS = 2;
  localparam int RG = 2;
  localparam int CW = $clog2(NB + 1);

  logic            frame_clk;
  logic            Reset_n;
  logic [2:0]      command;
  logic [3:0]      mapX;
  logic [3:0]      mapY;
  logic [CW-1:0]   bomb_limit;
  logic [3*NB-1:0] slot_state;
  logic [4*NB-1:0] slot_x;
  logic [4*NB-1:0] slot_y;
  logic [CW-1:0]   active_count;
  logic            placed;
  logic            place_reject;

  bomb_pool #(
    .MAX_BOMBS    (NB),
    .CNT_W        (10),
    .FUSE_TICKS   (FU),
    .FLAME_TICKS  (FL),
    .RESTORE_TICKS(RS),
    .FLAME_RANGE  (RG)
  ) dut (
    .frame_clk   (frame_clk),
    .Reset_n     (Reset_n),
    .command     (command),
    .mapX        (mapX),
    .mapY        (mapY),
    .bomb_limit  (bomb_limit),
    .slot_state  (slot_state),
    .slot_x      (slot_x),
    .slot_y      (slot_y),
    .active_count(active_count),
    .placed      (placed),
    .place_reject(place_reject)
  );

  // ---------------- clock / reset ----------------
  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // A bomb is described by when its flame starts (mfs); every phase follows from that.
  int cyc = 0;
  bit mvalid [NB];
  int mfs    [NB];
  int mx     [NB];
  int my     [NB];
  bit mprev4;
  bit eplaced;
  bit ereject;

  function automatic int phase_at(input int i, input int t);
    if (!mvalid[i])             return 2;
    if (t < mfs[i])             return 0;
    if (t < mfs[i] + FL)        return 1;
    if (t < mfs[i] + FL + RS)   return 3;
    return 2;
  endfunction

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_step();
    int cur [NB];
    bit trig[NB];
    int act;
    int fslot;
    bit req;
    bit dup;
    if (!Reset_n) begin
      for (int i = 0; i < NB; i++) begin
        mvalid[i] = 1'b0;
        mx[i]     = 0;
        my[i]     = 0;
      end
      mprev4  = 1'b0;
      eplaced = 1'b0;
      ereject = 1'b0;
      return;
    end
    act   = 0;
    fslot = -1;
    dup   = 1'b0;
    for (int i = 0; i < NB; i++) begin
      cur[i]  = phase_at(i, cyc);
      trig[i] = 1'b0;
      if (cur[i] != 2) begin
        act++;
        if (mx[i] == int'(mapX) && my[i] == int'(mapY)) dup = 1'b1;
      end else if (fslot < 0) begin
        fslot = i;
      end
    end
`ifdef CHAIN_REACTION_EN
    for (int j = 0; j < NB; j++)
      for (int i = 0; i < NB; i++)
        if (i != j && cur[j] == 0 && cur[i] == 1 &&
            ((my[i] == my[j] && absd(mx[i], mx[j]) <= RG) ||
             (mx[i] == mx[j] && absd(my[i], my[j]) <= RG)))
          trig[j] = 1'b1;
`endif
    cyc++;
    req     = (command == 3'd4) && !mprev4;
    mprev4  = (command == 3'd4);
    eplaced = 1'b0;
    ereject = 1'b0;
    if (req) begin
      if (act < int'(bomb_limit) && fslot >= 0 && !dup) begin
        mvalid[fslot] = 1'b1;
        mfs[fslot]    = cyc + FU;
        mx[fslot]     = int'(mapX);
        my[fslot]     = int'(mapY);
        eplaced       = 1'b1;
      end else begin
        ereject = 1'b1;
      end
    end
    for (int j = 0; j < NB; j++) if (trig[j]) mfs[j] = cyc;
  endtask

  initial begin
    forever begin
      @(posedge frame_clk or negedge Reset_n);
      model_step();
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge frame_clk);
      if (chk_en) begin
        int exp_act;
        exp_act = 0;
        for (int i = 0; i < NB; i++) begin
          chk($sformatf("slot%0d_state", i), int'(slot_state[3*i +: 3]), phase_at(i, cyc));
          chk($sformatf("slot%0d_x", i), int'(slot_x[4*i +: 4]), mx[i]);
          chk($sformatf("slot%0d_y", i), int'(slot_y[4*i +: 4]), my[i]);
          if (phase_at(i, cyc) != 2) exp_act++;
        end
        chk("active_count", int'(active_count), exp_act);
        chk("placed", int'(placed), int'(eplaced));
        chk("place_reject", int'(place_reject), int'(ereject));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input int c, input int x, input int y);
    command = 3'(c);
    mapX    = 4'(x);
    mapY    = 4'(y);
    @(posedge frame_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 0);
  endtask

  int seq_exp[10];
  int pulses;
  int waited;

  initial begin
    Reset_n    = 1'b0;
    command    = 3'd0;
    mapX       = 4'd0;
    mapY       = 4'd0;
    bomb_limit = 3'd4;
    idle(2);
    chk_en  = 1'b1;
    idle(1);
    Reset_n = 1'b1;

    // Scenario 1: asynchronous reset in the middle of a countdown
    tick(4, 1, 2);
    tick(0, 0, 0);
    tick(4, 2, 2);
    idle(2);
    #2 Reset_n = 1'b0;
    #1;
    for (int i = 0; i < NB; i++)
      chk($sformatf("async_rst_slot%0d", i), int'(slot_state[3*i +: 3]), 2);
    chk("async_rst_active", int'(active_count), 0);
    idle(2);
    Reset_n = 1'b1;
    tick(4, 7, 7);
    chk("post_rst_slot0_bomb", int'(slot_state[2:0]), 0);
    chk("post_rst_slot0_x", int'(slot_x[3:0]), 7);
    chk("post_rst_placed", int'(placed), 1);
    idle(10);

    // Scenario 2: single bomb timeline, 4 BOMB / 3 FLAME / 2 RESTORE / EMPTY
    seq_exp = '{0, 0, 0, 0, 1, 1, 1, 3, 3, 2};
    tick(4, 3, 5);
    chk("s2_placed", int'(placed), 1);
    chk("s2_x", int'(slot_x[3:0]), 3);
    chk("s2_y", int'(slot_y[3:0]), 5);
    for (int n = 0; n < 10; n++) begin
      if (n > 0) tick(0, 0, 0);
      chk($sformatf("s2_phase_%0d", n), int'(slot_state[2:0]), seq_exp[n]);
    end
    idle(2);

    // Scenario 3: held Release places once; duplicate tile is refused
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      tick(4, 6, 6);
      pulses += int'(placed);
    end
    chk("s3_hold_pulses", pulses, 1);
    tick(0, 0, 0);
    tick(4, 6, 6);
    tick(0, 0, 0);
    tick(4, 6, 6);
    chk("s3_dup_reject", int'(place_reject), 1);
    chk("s3_dup_active", int'(active_count), 1);
    idle(12);

    // Scenario 4: bomb limit of two, then slot 0 reused
    bomb_limit = 3'd2;
    tick(4, 1, 1);
    tick(0, 0, 0);
    tick(4, 2, 1);
    tick(0, 0, 0);
    tick(4, 3, 1);
    chk("s4_limit_reject", int'(place_reject), 1);
    chk("s4_slot0_x", int'(slot_x[3:0]), 1);
    chk("s4_slot1_x", int'(slot_x[7:4]), 2);
    waited = 0;
    while (slot_state[2:0] != 3'd2 && waited < 20) begin
      tick(0, 0, 0);
      waited++;
    end
    chk("s4_slot0_empty_timeout", int'(slot_state[2:0]), 2);
    tick(4, 4, 1);
    chk("s4_reuse_placed", int'(placed), 1);
    chk("s4_reuse_slot0_x", int'(slot_x[3:0]), 4);
    chk("s4_slot1_still_live", int'(slot_state[5:3] != 3'd2), 1);
    idle(12);

    // Scenarios 5/6: chain detonation along a row
    bomb_limit = 3'd4;
    tick(4, 2, 2);
    tick(0, 0, 0);
    tick(4, 4, 2);
    tick(0, 0, 0);
    tick(4, 5, 2);
    chk("s5_a_flame", int'(slot_state[2:0]), 1);
    tick(0, 0, 0);
`ifdef CHAIN_REACTION_EN
    chk("s5_b_chained", int'(slot_state[5:3]), 1);
`else
    chk("s6_b_own_fuse", int'(slot_state[5:3]), 0);
`endif
    chk("s5_c_not_by_a", int'(slot_state[8:6]), 0);
    tick(0, 0, 0);
`ifdef CHAIN_REACTION_EN
    chk("s5_c_cascade", int'(slot_state[8:6]), 1);
`else
    chk("s6_b_flame_age4", int'(slot_state[5:3]), 1);
    chk("s6_c_still_bomb", int'(slot_state[8:6]), 0);
`endif
    idle(15);

    // Random releases on a small map so duplicates, limits and chains all occur
    for (int n = 0; n < 400; n++) begin
      int c;
      bomb_limit = 3'($urandom_range(0, 4));
      c = ($urandom_range(0, 1) == 1) ? 4 : int'($urandom_range(0, 7));
      tick(c, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      if (n == 200) begin
        #2 Reset_n = 1'b0;
        tick(0, 0, 0);
        Reset_n = 1'b1;
      end
    end
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
